load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage initiator for the 64-bit data memory. It accepts load/store requests from the pipeline over a valid/ready handshake and drives the memory's `MemRead`/`MemWrite`/`address`/`write_data` side. Byte, half and word stores use read-modify-write. Load results are byte-lane extracted and sign/zero-extended. The result returns to the pipeline over a second valid/ready handshake.

## Interface
Parameters:
- `ADDR_BITS`, default 11: byte-address bits backed by memory (256 doublewords). Any higher address bit set means out of range.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit accepts a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = doubleword.
- `req_unsigned`  in  1  zero-extend the load (ignored for stores and doublewords).
- `req_addr`  in  64  byte address.
- `req_wdata`  in  64  store data, right-aligned.
- `resp_valid`  out  1  result present.
- `resp_ready`  in  1  consumer takes the result.
- `resp_rdata`  out  64  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or out-of-range access.
- `mem_read`  out  1  memory read enable.
- `mem_write`  out  1  memory write enable.
- `mem_addr`  out  64  doubleword-aligned address (bits [2:0] = 0).
- `mem_wdata`  out  64  full doubleword to write.
- `mem_rdata`  in  64  memory read data, combinational in the same cycle as `mem_read`.

## Operation
- FSM states: IDLE, RD, WR, RESP. `req_ready` = (state == IDLE).
- Accept on `req_valid && req_ready`. Register the request fields, then transition:
  - Error: `req_addr` not aligned to 2^`req_size` bytes, or `req_addr[63:ADDR_BITS]` != 0. Go to RESP with `resp_err`=1. No memory access.
  - Load: go to RD.
  - Doubleword store: go to WR with `mem_wdata` = `req_wdata`.
  - Sub-doubleword store: go to RD, then WR.
- RD: `mem_read`=1 for exactly one cycle. Capture `mem_rdata` at the end of that cycle.
  - Load: extract lane at byte offset `addr[2:0]`, sign- or zero-extend to 64 bits, go to RESP.
  - Store: merge `req_wdata[8·2^size−1:0]` into the captured doubleword at offset `addr[2:0]`, go to WR.
- WR: `mem_write`=1 for exactly one cycle with merged data, then go to RESP.
- RESP: hold `resp_valid`=1 with stable `resp_rdata`/`resp_err` until `resp_ready`=1, then go to IDLE.
- `mem_read` and `mem_write` are never high together.
- The memory writes level-sensitively, so `mem_addr`, `mem_wdata` and `mem_write` come straight from flops. They must be glitch-free and stable for the whole WR cycle.
- `mem_addr`, `mem_wdata`, `mem_read` and `mem_write` are 0 in IDLE and RESP.

## Timing
- Reset values while `rst_n`=0: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- Latency from acceptance edge to first `resp_valid` cycle:
  - Load: 2 cycles.
  - Doubleword store: 2 cycles.
  - Sub-doubleword store: 3 cycles.
  - Error: 1 cycle.
- Throughput: one outstanding request. The next acceptance occurs at the earliest in the cycle after the RESP handshake.
- Reset asserted mid-operation aborts immediately: all outputs go to reset values and any half-finished read-modify-write is dropped. Memory contents are not touched beyond what was already written.
- `resp_ready` held high: RESP lasts one cycle.

## Structure
- `lsu_pkg` holds:
  - FSM state enum.
  - Size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`.
  - A function returning the byte-mask for (size, offset).
- Sub-module `lsu_lane_align` (combinational): load extract/extend and store merge. It is shared by RD→RESP and RD→WR.
- Top module: FSM, request/response registers, error check.

## Test plan
- Doubleword store `addr`=0x18, data 0x1122334455667788, then doubleword load at 0x18 → `resp_rdata`=0x1122334455667788. Check `mem_write` pulses once with `mem_addr`=0x18. Check response timing.
- Byte store 0xAB at 0x1D over existing 0x1122334455667788 at 0x18 → WR data 0x1122AB4455667788. Then byte load signed at 0x1D → 0xFFFFFFFFFFFFFFAB; unsigned → 0xAB.
- Half load at 0x13 → `resp_err`=1, `resp_rdata`=0, `mem_read`/`mem_write` never asserted, response 1 cycle after acceptance. Load at 0x800 (ADDR_BITS=11) → `resp_err`=1.
- Word load at 0x1C (signed) after the byte store → 0x000000001122AB44. Hold `resp_ready`=0 for 4 cycles → `resp_valid` and data stable, `req_ready`=0 throughout.
- Assert `rst_n`=0 during WR of a word store → all outputs at reset values in the same cycle. After release, `req_ready`=1 and a reload of the target address shows either the old or the fully new doubleword, never a partial merge.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, size encodings and byte-mask helper for the load/store unit
//
// Purpose : FSM state enum, access-size encodings and the (size, offset) byte-lane mask.
// Ports   : none (package).

package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   // One bit per byte lane of the doubleword touched by an access of
   // 2^size bytes starting at byte offset off.
   function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
      logic [15:0] m;
      m = (16'd1 << (4'd1 << size)) - 16'd1;
      m = m << off;
      return m[7:0];
   endfunction

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] align_mask(input logic [1:0] size);
      logic [3:0] m;
      m = (4'd1 << size) - 4'd1;
      return m[2:0];
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane extract/extend for loads and merge for stores
//
// Purpose : combinational lane logic shared by the load return and the
//           read-modify-write store path.
// Ports   : size_i/unsigned_i/off_i - registered request attributes
//           rdata_i  - doubleword read from memory
//           wdata_i  - right-aligned store data
//           load_o   - extracted and sign/zero-extended load result
//           merge_o  - rdata_i with the store bytes substituted

module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [2:0]  off_i,
   input  logic [63:0] rdata_i,
   input  logic [63:0] wdata_i,
   output logic [63:0] load_o,
   output logic [63:0] merge_o
);

   logic [63:0] shifted;
   logic [63:0] wshift;
   logic [7:0]  mask;

   always_comb begin
      shifted = rdata_i >> {off_i, 3'b000};
      wshift  = wdata_i << {off_i, 3'b000};
      mask    = byte_mask(size_i, off_i);

      case (size_i)
         SZ_B:    load_o = unsigned_i ? {56'd0, shifted[7:0]}
                                      : {{56{shifted[7]}}, shifted[7:0]};
         SZ_H:    load_o = unsigned_i ? {48'd0, shifted[15:0]}
                                      : {{48{shifted[15]}}, shifted[15:0]};
         SZ_W:    load_o = unsigned_i ? {32'd0, shifted[31:0]}
                                      : {{32{shifted[31]}}, shifted[31:0]};
         default: load_o = shifted;
      endcase

      // Bytes outside the mask keep memory contents, so store data above
      // the access size never leaks into neighbouring lanes.
      for (int i = 0; i < 8; i++) begin
         merge_o[8*i +: 8] = mask[i] ? wshift[8*i +: 8] : rdata_i[8*i +: 8];
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store initiator for the 64-bit data memory
//
// Purpose : accepts pipeline load/store requests, performs read-modify-write for
//           sub-doubleword stores, returns extended load data or an error.
// Ports   : clk, rst_n               - clock, async active-low reset
//           req_*                    - request handshake and fields
//           resp_*                   - response handshake, data and error flag
//           mem_read/mem_write/mem_addr/mem_wdata/mem_rdata - memory side

module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_BITS = 11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata
);

   lsu_state_e  state_q, state_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [2:0]  off_q, off_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [63:0] mem_addr_q, mem_addr_d;
   logic [63:0] mem_wdata_q, mem_wdata_d;

   logic [63:0] ld_data;
   logic [63:0] st_merged;
   logic        bad_req;

   lsu_lane_align u_align (
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .off_i      (off_q),
      .rdata_i    (mem_rdata),
      .wdata_i    (wdata_q),
      .load_o     (ld_data),
      .merge_o    (st_merged)
   );

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      // Memory strobes and address/data are cleared unless a branch drives them,
      // which keeps them at zero in IDLE and RESP.
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;

      bad_req = (|(req_addr[2:0] & align_mask(req_size))) || (|req_addr[63:ADDR_BITS]);

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               size_d  = req_size;
               uns_d   = req_unsigned;
               off_d   = req_addr[2:0];
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = 1'b0;
               if (bad_req) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else if (req_write && (req_size == SZ_D)) begin
                  state_d     = ST_WR;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {req_addr[63:3], 3'b000};
                  mem_wdata_d = req_wdata;
               end else begin
                  state_d    = ST_RD;
                  mem_read_d = 1'b1;
                  mem_addr_d = {req_addr[63:3], 3'b000};
               end
            end
         end
         ST_RD: begin
            if (write_q) begin
               state_d     = ST_WR;
               mem_write_d = 1'b1;
               mem_addr_d  = mem_addr_q;
               mem_wdata_d = st_merged;
            end else begin
               state_d = ST_RESP;
               rdata_d = ld_data;
            end
         end
         ST_WR: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         write_q     <= 1'b0;
         size_q      <= SZ_B;
         uns_q       <= 1'b0;
         off_q       <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
//
// Purpose : drives directed load/store vectors against a 256-doubleword memory
//           model and compares results, timing and memory-side strobes.
// Ports   : none (top-level bench).

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   logic [63:0] mem [256];
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          overlap_cnt = 0;
   logic [63:0] wr_addr = '0;
   logic [63:0] wr_data = '0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_BITS(11)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   assign mem_rdata = mem_read ? mem[mem_addr[10:3]] : 64'd0;

   always @(negedge clk) begin
      if (mem_write) begin
         mem[mem_addr[10:3]] <= mem_wdata;
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= mem_addr;
         wr_data <= mem_wdata;
      end
      if (mem_read) rd_cnt <= rd_cnt + 1;
      if (mem_read && mem_write) overlap_cnt <= overlap_cnt + 1;
   end

   task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] d);
      int n = 0;
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = d;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Leaves lat=99 if no response arrives within the budget.
   task automatic wait_resp(output int lat, output logic [63:0] d, output logic e);
      lat = 1;
      while (!resp_valid && lat < 30) begin
         @(posedge clk); #1; lat++;
      end
      if (!resp_valid) lat = 99;
      d = resp_rdata;
      e = resp_err;
      if (resp_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      #12;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 64'd0) begin
         errors++; $display("FAIL reset_resp got v=%b e=%b d=%h exp 0/0/0", resp_valid, resp_err, resp_rdata); end
      checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin
         errors++; $display("FAIL reset_mem got r=%b w=%b a=%h d=%h exp all 0", mem_read, mem_write, mem_addr, mem_wdata); end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_dword;
      int lat; logic [63:0] d; logic e; int w0;
      w0 = wr_cnt;
      issue(1'b1, 2'd3, 1'b0, 64'h18, 64'h1122334455667788);
      wait_resp(lat, d, e);
      checks++; if (lat !== 2) begin errors++; $display("FAIL sd_latency got=%0d exp=2", lat); end
      checks++; if (e !== 1'b0 || d !== 64'd0) begin errors++; $display("FAIL sd_resp got e=%b d=%h exp 0/0", e, d); end
      checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL sd_write_pulses got=%0d exp=1", wr_cnt - w0); end
      checks++; if (wr_addr !== 64'h18 || wr_data !== 64'h1122334455667788) begin
         errors++; $display("FAIL sd_write got a=%h d=%h exp 18/1122334455667788", wr_addr, wr_data); end
      issue(1'b0, 2'd3, 1'b0, 64'h18, 64'h0);
      wait_resp(lat, d, e);
      checks++; if (lat !== 2) begin errors++; $display("FAIL ld_latency got=%0d exp=2", lat); end
      checks++; if (d !== 64'h1122334455667788 || e !== 1'b0) begin
         errors++; $display("FAIL ld_data got=%h e=%b exp 1122334455667788/0", d, e); end
   endtask

   task automatic test_byte;
      int lat; logic [63:0] d; logic e; int w0; int r0;
      w0 = wr_cnt; r0 = rd_cnt;
      issue(1'b1, 2'd0, 1'b0, 64'h1D, 64'h123456789ABCDEAB);
      wait_resp(lat, d, e);
      checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency got=%0d exp=3", lat); end
      checks++; if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 1) begin
         errors++; $display("FAIL sb_pulses got w=%0d r=%0d exp 1/1", wr_cnt - w0, rd_cnt - r0); end
      checks++; if (wr_data !== 64'h1122AB4455667788 || wr_addr !== 64'h18) begin
         errors++; $display("FAIL sb_merge got a=%h d=%h exp 18/1122ab4455667788", wr_addr, wr_data); end
      issue(1'b0, 2'd0, 1'b0, 64'h1D, 64'h0);
      wait_resp(lat, d, e);
      checks++; if (d !== 64'hFFFFFFFFFFFFFFAB) begin errors++; $display("FAIL lb_signed got=%h exp=ffffffffffffffab", d); end
      issue(1'b0, 2'd0, 1'b1, 64'h1D, 64'h0);
      wait_resp(lat, d, e);
      checks++; if (d !== 64'h00000000000000AB) begin errors++; $display("FAIL lb_unsigned got=%h exp=ab", d); end
      issue(1'b0, 2'd1, 1'b0, 64'h1C, 64'h0);
      wait_resp(lat, d, e);
      checks++; if (d !== 64'hFFFFFFFFFFFFAB44) begin errors++; $display("FAIL lh_signed got=%h exp=ffffffffffffab44", d); end
      issue(1'b0, 2'd1, 1'b1, 64'h1E, 64'h0);
      wait_resp(lat, d, e);
      checks++; if (d !== 64'h0000000000001122) begin errors++; $display("FAIL lhu_top got=%h exp=1122", d); end
   endtask

   task automatic test_err;
      int lat; logic [63:0] d; logic e; int w0; int r0;
      w0 = wr_cnt; r0 = rd_cnt;
      issue(1'b0, 2'd1, 1'b0, 64'h13, 64'h0);
      wait_resp(lat, d, e);
      checks++; if (e !== 1'b1 || d !== 64'd0) begin errors++; $display("FAIL err_mis_half got e=%b d=%h exp 1/0", e, d); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL err_latency got=%0d exp=1", lat); end
      issue(1'b0, 2'd3, 1'b0, 64'h800, 64'h0);
      wait_resp(lat, d, e);
      checks++; if (e !== 1'b1 || d !== 64'd0) begin errors++; $display("FAIL err_range got e=%b d=%h exp 1/0", e, d); end
      issue(1'b1, 2'd2, 1'b0, 64'h1A, 64'hFFFFFFFF);
      wait_resp(lat, d, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_mis_word_store got e=%b exp=1", e); end
      checks++; if (wr_cnt !== w0 || rd_cnt !== r0) begin
         errors++; $display("FAIL err_no_mem_access got w=%0d r=%0d exp 0/0", wr_cnt - w0, rd_cnt - r0); end
   endtask

   task automatic test_word_hold;
      int lat; logic [63:0] d; logic e; int bad = 0;
      resp_ready = 1'b0;
      issue(1'b0, 2'd2, 1'b0, 64'h1C, 64'h0);
      wait_resp(lat, d, e);
      checks++; if (lat !== 2 || d !== 64'h000000001122AB44) begin
         errors++; $display("FAIL lw_signed got lat=%0d d=%h exp 2/000000001122ab44", lat, d); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (resp_valid !== 1'b1 || resp_rdata !== 64'h000000001122AB44 || req_ready !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable got bad_cycles=%0d exp=0", bad); end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL hold_release got v=%b rdy=%b exp 0/1", resp_valid, req_ready); end
      checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL rd_wr_overlap got=%0d exp=0", overlap_cnt); end
   endtask

   task automatic test_reset_mid;
      int lat; logic [63:0] d; logic e; int w0;
      w0 = wr_cnt;
      issue(1'b1, 2'd2, 1'b0, 64'h18, 64'hDEADBEEF);
      @(posedge clk); #1;
      checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_mid_in_wr got mem_write=%b exp=1", mem_write); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 64'd0 ||
                    mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin
         errors++; $display("FAIL rst_mid_outputs got rdy=%b v=%b w=%b a=%h d=%h exp reset values",
                            req_ready, resp_valid, mem_write, mem_addr, mem_wdata); end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
      issue(1'b0, 2'd3, 1'b0, 64'h18, 64'h0);
      wait_resp(lat, d, e);
      checks++; if (d !== 64'h1122AB4455667788 && d !== 64'h1122AB44DEADBEEF) begin
         errors++; $display("FAIL rst_mid_reload got=%h exp old or full new", d); end
      checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL rst_mid_writes got=%0d exp=0", wr_cnt - w0); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 64'd0;
      test_reset();
      test_dword();
      test_byte();
      test_err();
      test_word_hold();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
